// File: rtl/l1i_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module      : l1i_fetch_responder
// Description : Direct-mapped L1 instruction cache responder for predictor line
//               fetches; single outstanding miss refilled over a memory channel.
// Revision    : 1.0 - initial release
// ============================================================================
module l1i_fetch_responder #(
    parameter int CACHE_LINE_WIDTH = 64,
    parameter int SETS             = 64,
    parameter int PC_SIZE          = 64
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          bp_req_valid,
    input  logic [PC_SIZE-1:0]            bp_req_addr,
    input  logic                          inv_all_in,
    output logic                          l1i_ready,
    output logic                          l1i_valid,
    output logic [CACHE_LINE_WIDTH*8-1:0] l1i_cacheline,
    output logic [PC_SIZE-1:0]            l1i_resp_addr,
    output logic                          mem_req_valid,
    output logic [PC_SIZE-1:0]            mem_req_addr,
    input  logic                          mem_req_ready,
    input  logic                          mem_resp_valid,
    input  logic [CACHE_LINE_WIDTH*8-1:0] mem_resp_data
);

    localparam int c_OFF_W     = $clog2(CACHE_LINE_WIDTH);
    localparam int c_IDX_W     = $clog2(SETS);
    localparam int c_TAG_W     = PC_SIZE - c_OFF_W - c_IDX_W;
    localparam int c_LINE_BITS = CACHE_LINE_WIDTH * 8;

    localparam logic [PC_SIZE-1:0] c_LINE_MASK = {{(PC_SIZE-c_OFF_W){1'b1}}, {c_OFF_W{1'b0}}};

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_LOOKUP    = 3'd1;
    localparam logic [2:0] c_ST_MISS_REQ  = 3'd2;
    localparam logic [2:0] c_ST_MISS_WAIT = 3'd3;
    localparam logic [2:0] c_ST_RESPOND   = 3'd4;

    logic [2:0]             r_state;
    logic [PC_SIZE-1:0]     r_addr;
    logic [SETS-1:0]        r_valid;
    logic [c_TAG_W-1:0]     r_tag  [SETS];
    logic [c_LINE_BITS-1:0] r_data [SETS];
    logic                   r_drop;
    logic                   r_l1i_valid;
    logic [c_LINE_BITS-1:0] r_line;
    logic [PC_SIZE-1:0]     r_resp_addr;
    logic                   r_mem_req_valid;
    logic [PC_SIZE-1:0]     r_mem_req_addr;

    logic [c_IDX_W-1:0]     w_idx;
    logic [c_TAG_W-1:0]     w_tag;
    logic                   w_hit;
    logic                   w_refill;

    assign w_idx    = r_addr[c_OFF_W +: c_IDX_W];
    assign w_tag    = r_addr[PC_SIZE-1 -: c_TAG_W];
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_refill = (r_state == c_ST_MISS_WAIT) && mem_resp_valid;

    // Ready is gated by reset so the requester never sees it during the reset cycle.
    assign l1i_ready     = (r_state == c_ST_IDLE) && !rst_in;
    assign l1i_valid     = r_l1i_valid;
    assign l1i_cacheline = r_line;
    assign l1i_resp_addr = r_resp_addr;
    assign mem_req_valid = r_mem_req_valid;
    assign mem_req_addr  = r_mem_req_addr;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state         <= c_ST_IDLE;
            r_addr          <= '0;
            r_valid         <= '0;
            r_drop          <= 1'b0;
            r_l1i_valid     <= 1'b0;
            r_line          <= '0;
            r_resp_addr     <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_addr  <= '0;
        end else begin
            r_l1i_valid <= 1'b0;
            if (inv_all_in) begin
                r_valid <= '0;
            end
            case (r_state)
                c_ST_IDLE: begin
                    r_drop <= 1'b0;
                    if (bp_req_valid) begin
                        r_addr  <= bp_req_addr & c_LINE_MASK;
                        r_state <= c_ST_LOOKUP;
                    end
                end
                c_ST_LOOKUP: begin
                    if (w_hit) begin
                        r_l1i_valid <= 1'b1;
                        r_line      <= r_data[w_idx];
                        r_resp_addr <= r_addr;
                        r_state     <= c_ST_IDLE;
                    end else begin
                        r_mem_req_valid <= 1'b1;
                        r_mem_req_addr  <= r_addr;
                        r_state         <= c_ST_MISS_REQ;
                    end
                end
                c_ST_MISS_REQ: begin
                    if (inv_all_in) begin
                        r_drop <= 1'b1;
                    end
                    if (mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= c_ST_MISS_WAIT;
                    end
                end
                c_ST_MISS_WAIT: begin
                    if (inv_all_in) begin
                        r_drop <= 1'b1;
                    end
                    if (mem_resp_valid) begin
                        // Data bypasses the array; an invalidate seen during the miss keeps the set invalid.
                        r_line      <= mem_resp_data;
                        r_resp_addr <= r_addr;
                        r_l1i_valid <= 1'b1;
                        if (!(r_drop || inv_all_in)) begin
                            r_valid[w_idx] <= 1'b1;
                        end
                        r_state <= c_ST_RESPOND;
                    end
                end
                c_ST_RESPOND: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Tag and data storage need no reset: the valid bits qualify every entry.
    always_ff @(posedge clk_in) begin
        if (w_refill) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= mem_resp_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_l1i_fetch_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_l1i_fetch_responder
// Description : Self-checking bench for l1i_fetch_responder with a line-level
//               cache model and a scripted/randomized memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_l1i_fetch_responder;

    localparam int SETS = 64;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         bp_req_valid;
    logic [63:0]  bp_req_addr;
    logic         inv_all_in;
    logic         l1i_ready;
    logic         l1i_valid;
    logic [511:0] l1i_cacheline;
    logic [63:0]  l1i_resp_addr;
    logic         mem_req_valid;
    logic [63:0]  mem_req_addr;
    logic         mem_req_ready;
    logic         mem_resp_valid;
    logic [511:0] mem_resp_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: per set, whether it holds a line, which line-aligned address, and its data.
    bit           m_valid     [SETS];
    logic [63:0]  m_line_addr [SETS];
    logic [511:0] m_data      [SETS];

    l1i_fetch_responder #(
        .CACHE_LINE_WIDTH(64),
        .SETS            (SETS),
        .PC_SIZE         (64)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .bp_req_valid  (bp_req_valid),
        .bp_req_addr   (bp_req_addr),
        .inv_all_in    (inv_all_in),
        .l1i_ready     (l1i_ready),
        .l1i_valid     (l1i_valid),
        .l1i_cacheline (l1i_cacheline),
        .l1i_resp_addr (l1i_resp_addr),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [511:0] rand_line();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [63:0] line_of(input logic [63:0] a);
        return a - (a % 64);
    endfunction

    function automatic int set_of(input logic [63:0] a);
        return int'((a / 64) % SETS);
    endfunction

    function automatic bit model_would_hit(input logic [63:0] a);
        return m_valid[set_of(a)] && (m_line_addr[set_of(a)] == line_of(a));
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < SETS; i++) m_valid[i] = 1'b0;
    endfunction

    // mode: 0 none, 1 invalidate at accept edge, 2 invalidate in MISS_WAIT, 3 invalidate with response
    function automatic void model_fetch(input logic [63:0] a, input int mode, input logic [511:0] data,
                                        output bit hit, output logic [511:0] exp_line);
        if (mode == 1) model_clear();
        hit = model_would_hit(a);
        if (hit) begin
            exp_line = m_data[set_of(a)];
        end else begin
            exp_line = data;
            if (mode == 2 || mode == 3) begin
                model_clear();
            end else begin
                m_valid[set_of(a)]     = 1'b1;
                m_line_addr[set_of(a)] = line_of(a);
                m_data[set_of(a)]      = data;
            end
        end
    endfunction

    // Issues one request and plays the memory side; reports what was observed.
    task automatic fetch(input logic [63:0] addr, input int rdy_dly, input int rsp_dly, input int mode,
                         input logic [511:0] data,
                         output bit got_req, output logic [63:0] req_addr, output bit req_unstable,
                         output bit ready_leak, output int pulses, output int latency,
                         output logic [511:0] line, output logic [63:0] raddr, output logic ready_after);
        int wait_cnt;
        int rsp_cnt;
        bit hs;
        bit sent;
        got_req = 0; req_addr = 'x; req_unstable = 0; ready_leak = 0;
        pulses = 0; latency = -1; line = 'x; raddr = 'x; ready_after = 1'bx;
        wait_cnt = 0; rsp_cnt = 0; hs = 0; sent = 0;
        bp_req_valid = 1'b1;
        bp_req_addr  = addr;
        inv_all_in   = (mode == 1);
        @(posedge clk_in); #1;
        bp_req_valid = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            inv_all_in     = 1'b0;
            if (l1i_ready && !l1i_valid && latency < 0) ready_leak = 1;
            if (l1i_valid) begin
                pulses++;
                if (latency < 0) begin
                    latency = k;
                    line    = l1i_cacheline;
                    raddr   = l1i_resp_addr;
                end
            end
            if (latency >= 0 && k == latency + 1) ready_after = l1i_ready;
            if (hs && !sent) begin
                if (rsp_cnt == rsp_dly) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = data;
                    inv_all_in     = (mode == 3);
                    sent = 1;
                end else begin
                    inv_all_in = (mode == 2 && rsp_cnt == 0);
                end
                rsp_cnt++;
            end
            if (mem_req_valid) begin
                if (!got_req) begin
                    got_req  = 1;
                    req_addr = mem_req_addr;
                end else if (mem_req_addr !== req_addr) begin
                    req_unstable = 1;
                end
                if (wait_cnt >= rdy_dly) begin
                    mem_req_ready = 1'b1;
                    hs = 1;
                end
                wait_cnt++;
            end else if (got_req && !hs) begin
                req_unstable = 1;
            end
            if (latency >= 0 && k >= latency + 2) break;
            @(posedge clk_in); #1;
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        inv_all_in     = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; bp_req_valid = 1'b0; bp_req_addr = '0; inv_all_in = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        model_clear();
        repeat (2) @(posedge clk_in);
        #1;
        n_checks++; if (l1i_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_reset: got %b exp 0", l1i_ready); end
        n_checks++; if (l1i_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", l1i_valid); end
        n_checks++; if (l1i_cacheline !== '0) begin n_fail++; $display("FAIL reset_line: got %h exp 0", l1i_cacheline); end
        n_checks++; if (l1i_resp_addr !== 64'h0) begin n_fail++; $display("FAIL reset_resp_addr: got %h exp 0", l1i_resp_addr); end
        n_checks++; if (mem_req_valid !== 1'b0 || mem_req_addr !== 64'h0) begin
            n_fail++; $display("FAIL reset_mem_req: got valid %b addr %h exp 0/0", mem_req_valid, mem_req_addr); end
        rst_in = 1'b0;
        #1;
        n_checks++; if (l1i_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b exp 1", l1i_ready); end
    endtask

    logic [511:0] line_d;

    task automatic test_cold_miss();
        bit got_req, unst, leak, hit; logic [63:0] ra, rsp; int p, lat; logic [511:0] ln, exp; logic ra_ok;
        line_d = rand_line();
        model_fetch(64'h1000, 0, line_d, hit, exp);
        fetch(64'h1000, 0, 0, 0, line_d, got_req, ra, unst, leak, p, lat, ln, rsp, ra_ok);
        n_checks++; if (got_req !== 1'b1 || ra !== 64'h1000) begin n_fail++; $display("FAIL cold_mem_req: got req %b addr %h exp 1 addr 1000", got_req, ra); end
        n_checks++; if (ln !== exp) begin n_fail++; $display("FAIL cold_line: got %h exp %h", ln, exp); end
        n_checks++; if (p !== 1 || lat !== 4) begin n_fail++; $display("FAIL cold_timing: got pulses %0d lat %0d exp 1/4", p, lat); end
        n_checks++; if (rsp !== 64'h1000 || leak || ra_ok !== 1'b1) begin
            n_fail++; $display("FAIL cold_addr_ready: got resp %h leak %b ready_after %b exp 1000/0/1", rsp, leak, ra_ok); end
    endtask

    task automatic test_hit();
        bit got_req, unst, leak, hit; logic [63:0] ra, rsp; int p, lat; logic [511:0] ln, exp; logic ra_ok;
        model_fetch(64'h1024, 0, rand_line(), hit, exp);
        fetch(64'h1024, 0, 0, 0, rand_line(), got_req, ra, unst, leak, p, lat, ln, rsp, ra_ok);
        n_checks++; if (got_req !== 1'b0) begin n_fail++; $display("FAIL hit_no_mem_req: got %b exp 0", got_req); end
        n_checks++; if (p !== 1 || lat !== 2) begin n_fail++; $display("FAIL hit_timing: got pulses %0d lat %0d exp 1/2", p, lat); end
        n_checks++; if (ln !== line_d || ln !== exp) begin n_fail++; $display("FAIL hit_line: got %h exp %h", ln, line_d); end
        n_checks++; if (rsp !== 64'h1000) begin n_fail++; $display("FAIL hit_resp_addr: got %h exp 1000", rsp); end
    endtask

    task automatic test_conflict();
        bit got_req, unst, leak, hit; logic [63:0] ra, rsp; int p, lat; logic [511:0] ln, exp, e; logic ra_ok;
        logic [63:0] alias_a;
        alias_a = 64'h1000 + 64 * SETS;
        e = rand_line();
        model_fetch(alias_a, 0, e, hit, exp);
        fetch(alias_a, 0, 0, 0, e, got_req, ra, unst, leak, p, lat, ln, rsp, ra_ok);
        n_checks++; if (got_req !== 1'b1 || ra !== alias_a || ln !== e || rsp !== alias_a) begin
            n_fail++; $display("FAIL conflict_alias_miss: got req %b addr %h resp %h line %h exp 1 %h %h %h", got_req, ra, rsp, ln, alias_a, alias_a, e); end
        e = rand_line();
        model_fetch(64'h1000, 0, e, hit, exp);
        fetch(64'h1000, 0, 0, 0, e, got_req, ra, unst, leak, p, lat, ln, rsp, ra_ok);
        n_checks++; if (got_req !== 1'b1 || ln !== exp || lat !== 4) begin
            n_fail++; $display("FAIL conflict_replaced_miss: got req %b lat %0d line %h exp 1 4 %h", got_req, lat, ln, exp); end
    endtask

    task automatic test_stall();
        bit got_req, unst, leak, hit; logic [63:0] ra, rsp; int p, lat; logic [511:0] ln, exp, d; logic ra_ok;
        d = rand_line();
        model_fetch(64'h5_0040, 0, d, hit, exp);
        fetch(64'h5_0047, 5, 2, 0, d, got_req, ra, unst, leak, p, lat, ln, rsp, ra_ok);
        n_checks++; if (unst || ra !== 64'h5_0040) begin n_fail++; $display("FAIL stall_req_stable: got unstable %b addr %h exp 0 50040", unst, ra); end
        n_checks++; if (leak) begin n_fail++; $display("FAIL stall_ready_low: got ready during miss exp 0"); end
        n_checks++; if (lat !== 11 || p !== 1 || ln !== exp) begin
            n_fail++; $display("FAIL stall_response: got lat %0d pulses %0d line %h exp 11 1 %h", lat, p, ln, exp); end
    endtask

    task automatic test_invalidate();
        bit got_req, unst, leak, hit; logic [63:0] ra, rsp; int p, lat; logic [511:0] ln, exp, f;
        logic ra_ok;
        logic [63:0] a;
        int mode;
        for (int m = 1; m <= 3; m++) begin
            a = 64'h7_0000 + 64'(m) * 64'h80;
            mode = m;
            f = rand_line();
            model_fetch(a, mode, f, hit, exp);
            fetch(a, 1, 2, mode, f, got_req, ra, unst, leak, p, lat, ln, rsp, ra_ok);
            n_checks++; if (got_req !== 1'b1 || ln !== f || p !== 1) begin
                n_fail++; $display("FAIL inv_mode%0d_data: got req %b pulses %0d line %h exp 1 1 %h", m, got_req, p, ln, f); end
            f = rand_line();
            model_fetch(a, 0, f, hit, exp);
            fetch(a, 0, 0, 0, f, got_req, ra, unst, leak, p, lat, ln, rsp, ra_ok);
            n_checks++; if (got_req !== !hit || ln !== exp) begin
                n_fail++; $display("FAIL inv_mode%0d_rerequest: got req %b line %h exp %b %h", m, got_req, ln, !hit, exp); end
        end
    endtask

    task automatic test_random();
        bit got_req, unst, leak, hit, pred; logic [63:0] ra, rsp, a; int p, lat, rd, sd, mode, r;
        logic [511:0] ln, exp, d; logic ra_ok;
        logic [63:0] pool [6];
        pool[0] = 64'h1000; pool[1] = 64'h2000; pool[2] = 64'h2040;
        pool[3] = 64'hFFFF_FFFF_FFFF_F000; pool[4] = 64'h8000_0000_0000_1000; pool[5] = 64'h3FC0;
        for (int it = 0; it < 40; it++) begin
            a  = pool[$urandom_range(5)] + 64'($urandom_range(63));
            rd = $urandom_range(3);
            sd = 1 + $urandom_range(2);
            r  = $urandom_range(7);
            pred = model_would_hit(a);
            mode = 0;
            if (r == 0) mode = 1;
            else if (!pred && r == 1) mode = 2;
            else if (!pred && r == 2) mode = 3;
            d = rand_line();
            model_fetch(a, mode, d, hit, exp);
            fetch(a, rd, sd, mode, d, got_req, ra, unst, leak, p, lat, ln, rsp, ra_ok);
            n_checks++; if (ln !== exp || rsp !== line_of(a)) begin
                n_fail++; $display("FAIL rand%0d_data: got line %h addr %h exp %h %h", it, ln, rsp, exp, line_of(a)); end
            n_checks++; if (got_req !== !hit || lat !== (hit ? 2 : 4 + rd + sd) || p !== 1 || leak || unst || ra_ok !== 1'b1) begin
                n_fail++; $display("FAIL rand%0d_protocol: got req %b lat %0d pulses %0d leak %b unst %b rdy %b exp req %b lat %0d",
                                   it, got_req, lat, p, leak, unst, ra_ok, !hit, hit ? 2 : 4 + rd + sd); end
        end
    endtask

    task automatic test_reset_mid_miss();
        bit got_req, unst, leak, hit, seen_valid, reached; logic [63:0] ra, rsp; int p, lat;
        logic [511:0] ln, exp, y; logic ra_ok;
        reached = 0;
        bp_req_valid = 1'b1; bp_req_addr = 64'h9_0000;
        @(posedge clk_in); #1;
        bp_req_valid = 1'b0;
        for (int k = 0; k < 20 && !reached; k++) begin
            if (mem_req_valid) begin
                mem_req_ready = 1'b1;
                reached = 1;
            end
            @(posedge clk_in); #1;
            mem_req_ready = 1'b0;
        end
        n_checks++; if (!reached) begin n_fail++; $display("FAIL rstmid_no_mem_req: got none exp mem_req_valid"); end
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        model_clear();
        #1;
        n_checks++; if (l1i_ready !== 1'b1 || l1i_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_after: got ready %b valid %b memreq %b exp 1 0 0", l1i_ready, l1i_valid, mem_req_valid); end
        mem_resp_valid = 1'b1; mem_resp_data = rand_line();
        @(posedge clk_in); #1;
        mem_resp_valid = 1'b0;
        seen_valid = 0;
        for (int k = 0; k < 3; k++) begin
            if (l1i_valid) seen_valid = 1;
            @(posedge clk_in); #1;
        end
        n_checks++; if (seen_valid) begin n_fail++; $display("FAIL rstmid_late_resp: got l1i_valid exp 0"); end
        y = rand_line();
        model_fetch(64'h9_0000, 0, y, hit, exp);
        fetch(64'h9_0000, 0, 0, 0, y, got_req, ra, unst, leak, p, lat, ln, rsp, ra_ok);
        n_checks++; if (got_req !== 1'b1 || ln !== y) begin n_fail++; $display("FAIL rstmid_refetch: got req %b line %h exp 1 %h", got_req, ln, y); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_stall();
        test_invalidate();
        test_reset_mid_miss();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
